// File: rtl/dm_lsu.sv
// Load/store unit between MEM and data memory: posted in-order store buffer, load forwarding.
// Optional build macro LSU_FWD_EN: forward buffered store data to loads instead of stalling them.
module dm_lsu #(
    parameter int SB_DEPTH  = 2,
    parameter int MEM_WORDS = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    input  logic [2:0]  req_rd,
    output logic        req_ready,
    output logic [7:0]  dm_addr,
    output logic [15:0] dm_din,
    output logic        dm_we,
    input  logic [15:0] dm_dout,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_rd,
    output logic        err
);
    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic [7:0]          sb_addr [SB_DEPTH];
    logic [15:0]         sb_data [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld;
    logic [PW-1:0]       head, tail;
    logic [CW-1:0]       count;

    logic        in_range, full, hit, fire, load_fire, push, drain;
    logic [15:0] fwd_data, load_data;
    logic [PW-1:0] ptr;

    assign in_range = ({1'b0, req_addr} < 9'(MEM_WORDS));
    assign full     = (count == CW'(SB_DEPTH));

    // Walk from the oldest entry so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        ptr      = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld[ptr] && sb_addr[ptr] == req_addr) begin
                hit      = 1'b1;
                fwd_data = sb_data[ptr];
            end
            ptr = (ptr == PW'(SB_DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

`ifdef LSU_FWD_EN
    assign req_ready = req_we ? !full : 1'b1;
    assign load_data = !in_range ? 16'h0 : (hit ? fwd_data : dm_dout);
`else
    assign req_ready = req_we ? !full : !hit;
    assign load_data = in_range ? dm_dout : 16'h0;
`endif

    assign fire      = req_valid && req_ready;
    assign load_fire = fire && !req_we;
    assign push      = fire && req_we && in_range;
    assign drain     = !fire && (count != '0) && !reset;

    always_comb begin
        dm_we   = 1'b0;
        dm_addr = '0;
        dm_din  = '0;
        if (load_fire && in_range) begin
            dm_addr = req_addr;
        end else if (drain) begin
            dm_we   = 1'b1;
            dm_addr = sb_addr[head];
            dm_din  = sb_data[head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            sb_vld   <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rd    <= '0;
            err      <= 1'b0;
        end else begin
            wb_valid <= load_fire;
            err      <= fire && !in_range;
            if (load_fire) begin
                wb_data <= load_data;
                wb_rd   <= req_rd;
            end
            if (push) begin
                sb_addr[tail] <= req_addr;
                sb_data[tail] <= req_wdata;
                sb_vld[tail]  <= 1'b1;
                tail          <= (tail == PW'(SB_DEPTH - 1)) ? '0 : tail + 1'b1;
                count         <= count + 1'b1;
            end else if (drain) begin
                sb_vld[head]  <= 1'b0;
                head          <= (head == PW'(SB_DEPTH - 1)) ? '0 : head + 1'b1;
                count         <= count - 1'b1;
            end
        end
    end
endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit between the MEM pipeline stage and the data memory (DM). It accepts one load or store request per cycle and drives the DM port (8-bit address, 16-bit data, combinational read, write on clock edge). Stores are posted into a small in-order store buffer and written to DM in cycles with no accepted request. Loads read DM directly, or forward from the store buffer, and return a registered result to write-back.

## Interface
- `SB_DEPTH`, default 2: store buffer entries (1..4).
- `MEM_WORDS`, default 11: number of implemented DM words; valid addresses are 0..MEM_WORDS-1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 8: word address.
- `req_wdata` in 16: store data.
- `req_rd` in 3: destination register of a load.
- `req_ready` out 1: request accepted this cycle when `req_valid && req_ready` (combinational).
- `dm_addr` out 8: DM address.
- `dm_din` out 16: DM write data.
- `dm_we` out 1: DM write enable.
- `dm_dout` in 16: DM read data (combinational from `dm_addr`).
- `wb_valid` out 1: load result valid, one-cycle pulse.
- `wb_data` out 16: load result.
- `wb_rd` out 3: destination register of the load result.
- `err` out 1: one-cycle pulse for an accepted request whose address is ≥ MEM_WORDS.

## Operation
- The store buffer is a FIFO of {addr, data} with SB_DEPTH entries, an occupancy count, and wrapping head/tail pointers.
- **Load accept** (`req_valid && !req_we && req_ready`):
  - `dm_addr = req_addr` in the same cycle.
  - Result is `dm_dout`, or the forwarded value (see Configuration).
  - The result is registered into `wb_data`/`wb_rd` with `wb_valid`=1.
- **Store accept** (`req_valid && req_we && req_ready`): push {req_addr, req_wdata} at the tail. Nothing is written to DM this cycle.
- **Drain**: in any cycle with no handshake and a non-empty buffer:
  - `dm_we`=1, `dm_addr`/`dm_din` = head entry.
  - The head is popped at the clock edge.
  - A request that is present but stalled does not count as a handshake, so drain proceeds.
- `req_ready` is 0 for a store when the buffer is full.
- `req_ready` is 0 for a load only when forwarding is compiled out and the address matches a buffered entry.
- Otherwise `req_ready`=1.
- **Out of range** (address ≥ MEM_WORDS, either request type):
  - The request is accepted and `err` pulses the next cycle.
  - A load returns `wb_data`=0 with `wb_valid`=1.
  - A store is dropped and not pushed.
  - DM is never addressed out of range.
- When neither a load nor a drain uses the port: `dm_we`=0, `dm_addr`=0, `dm_din`=0.
- Stores are committed in program order. A load never observes DM data older than a buffered store to the same address.

## Timing
- Load latency: accepted in cycle N, `wb_valid`/`wb_data`/`wb_rd` valid in cycle N+1 for exactly one cycle.
- Store: pushed at the end of cycle N. The earliest DM write is cycle N+1, if that cycle has no handshake.
- Back-to-back requests: one per cycle with no bubbles, as long as `req_ready` stays 1.
- Full buffer plus stalled store:
  - The stall cycle drains one entry.
  - The store is accepted the next cycle. Worst case is a one-cycle stall.
- Occupancy changes per edge:
  - push without pop: +1
  - pop without push: −1
  - push and pop never occur in the same cycle.
- Reset (any cycle, including while entries are pending):
  - The buffer is emptied and pending stores are discarded, never written.
  - `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `err`=0.
  - `dm_we` is forced to 0 while `reset`=1.
  - `req_ready`=1 in the first cycle after reset.

## Configuration
- `LSU_FWD_EN` defined:
  - A load whose address matches one or more valid buffer entries takes the data of the youngest matching entry.
  - `req_ready` stays 1 and DM is not consulted.
- `LSU_FWD_EN` undefined:
  - A matching load is stalled (`req_ready`=0) until no matching entry remains.
  - Stall cycles drain the buffer, so the load completes after at most SB_DEPTH stall cycles and then reads DM.

## Test plan
- **Reset, then load.** Load addr 2 with `req_rd`=5 → next cycle `wb_valid`=1, `wb_data`=16'h0059, `wb_rd`=5, `dm_we` was 0 throughout.
- **Posted store.** Store addr 4 data 16'h1234, then one idle cycle → `dm_we`=1 with `dm_addr`=4 and `dm_din`=16'h1234 in the idle cycle. A subsequent load of addr 4 returns 16'h1234.
- **Forwarding.** Store addr 6 = 16'h00AA, store addr 6 = 16'h00BB, then load addr 6 immediately:
  - With `LSU_FWD_EN`: `wb_data`=16'h00BB with no stall.
  - Without: `req_ready`=0 for 2 cycles while two DM writes occur, then `wb_data`=16'h00BB.
- **Full buffer.** Three back-to-back stores (addrs 1, 2, 3), SB_DEPTH=2 → the third sees `req_ready`=0 for one cycle, during which addr 1 is drained. The third is accepted next. Final DM contents are in order.
- **Out of range.** Load addr 8'h0B → `err` and `wb_valid` both pulse with `wb_data`=0. Store addr 8'hFF → `err` pulses and no `dm_we` ever follows.
- **Reset mid-operation.** Two stores buffered, then assert `reset` for one cycle → no DM write occurs, and `req_ready`=1 after reset.
